// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative tag/data store with true-LRU replacement
module dcache_sram_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    parameter int IDX_W  = $clog2(SETS),
    parameter int WAY_W  = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W+1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic [TAG_W+1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic              evict_o
);
    logic [TAG_W+1:0]  r_tag  [SETS][WAYS];
    logic [LINE_W-1:0] r_data [SETS][WAYS];
    logic [WAY_W-1:0]  r_age  [SETS][WAYS];
    logic              w_hit;
    logic              w_has_inv;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_lru_way;
    logic [WAY_W-1:0]  w_sel;

    // scan the addressed set high-to-low so the lowest matching/invalid way wins
    always_comb begin
        w_hit     = 1'b0;
        w_has_inv = 1'b0;
        w_hit_way = '0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_tag[addr_i][w][TAG_W+1] && r_tag[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_tag[addr_i][w][TAG_W+1]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
            if (r_age[addr_i][w] == WAY_W'(WAYS - 1))
                w_lru_way = WAY_W'(w);
        end
    end

    assign hit_o = enable_i & w_hit;
    assign w_sel = w_hit ? w_hit_way : w_has_inv ? w_inv_way : w_lru_way;

    // arrays, ages and registered outputs; a read miss or idle cycle only clears evict_o
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]  <= '0;
                    r_data[s][w] <= '0;
                    r_age[s][w]  <= WAY_W'(w);
                end
            end
            tag_o   <= '0;
            data_o  <= '0;
            way_o   <= '0;
            evict_o <= 1'b0;
        end else begin
            evict_o <= 1'b0;
            if (enable_i && (w_hit || write_i)) begin
                tag_o  <= r_tag[addr_i][w_sel];
                data_o <= r_data[addr_i][w_sel];
                way_o  <= w_sel;
                for (int w = 0; w < WAYS; w++)
                    if (r_age[addr_i][w] < r_age[addr_i][w_sel])
                        r_age[addr_i][w] <= r_age[addr_i][w] + 1'b1;
                r_age[addr_i][w_sel] <= '0;
                if (write_i) begin
                    r_tag[addr_i][w_sel]  <= tag_i;
                    r_data[addr_i][w_sel] <= data_i;
                    evict_o               <= !w_hit && r_tag[addr_i][w_sel][TAG_W+1];
                end
            end
        end
    end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed and random accesses checked against a timestamp-LRU cache model
module tb_dcache_sram_nway;
    localparam int WAYS = 4, SETS = 16, TAG_W = 23, LINE_W = 256, TW = TAG_W + 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0]        addr_i;
    logic [TW-1:0]     tag_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i, write_i;
    logic [TW-1:0]     tag_o;
    logic [LINE_W-1:0] data_o;
    logic              hit_o;
    logic [1:0]        way_o;
    logic              evict_o;

    dcache_sram_nway dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
        .enable_i(enable_i), .write_i(write_i), .tag_o(tag_o), .data_o(data_o),
        .hit_o(hit_o), .way_o(way_o), .evict_o(evict_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    logic [TW-1:0]     m_tag  [SETS][WAYS];
    logic [LINE_W-1:0] m_data [SETS][WAYS];
    int                m_ts   [SETS][WAYS];
    int                now;
    logic [TW-1:0]     e_tag;
    logic [LINE_W-1:0] e_data;
    int                e_way;
    logic              e_evict;

    task automatic chk(string nm, logic [LINE_W-1:0] o, logic [LINE_W-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", nm, o, e);
        end
    endtask

    task automatic chk_outs(string nm);
        chk({nm, "_tag"}, LINE_W'(tag_o), LINE_W'(e_tag));
        chk({nm, "_data"}, data_o, e_data);
        chk({nm, "_way"}, LINE_W'(way_o), LINE_W'(e_way));
        chk({nm, "_evict"}, LINE_W'(evict_o), LINE_W'(e_evict));
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w] = '0;
                m_data[s][w] = '0;
                m_ts[s][w] = -w;
            end
        now = 0;
        e_tag = '0;
        e_data = '0;
        e_way = 0;
        e_evict = 1'b0;
    endfunction

    function automatic int find_hit(int s, logic [TW-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_tag[s][w][TW-1] && m_tag[s][w][TAG_W-1:0] == t[TAG_W-1:0]) return w;
        return -1;
    endfunction

    function automatic int victim(int s);
        int v = 0;
        for (int w = 0; w < WAYS; w++)
            if (!m_tag[s][w][TW-1]) return w;
        for (int w = 1; w < WAYS; w++)
            if (m_ts[s][w] < m_ts[s][v]) v = w;
        return v;
    endfunction

    function automatic logic [TW-1:0] mk(bit v, bit d, int t);
        return {v, d, TAG_W'(t)};
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic acc(string nm, bit en, bit wr, int s, logic [TW-1:0] t, logic [LINE_W-1:0] d);
        int h, v;
        @(negedge clk_i);
        enable_i = en;
        write_i  = wr;
        addr_i   = 4'(s);
        tag_i    = t;
        data_i   = d;
        #1;
        h = find_hit(s, t);
        chk({nm, "_hit"}, LINE_W'(hit_o), LINE_W'(en && h >= 0));
        e_evict = 1'b0;
        if (en && (h >= 0 || wr)) begin
            v = (h >= 0) ? h : victim(s);
            e_tag  = m_tag[s][v];
            e_data = m_data[s][v];
            e_way  = v;
            if (wr) begin
                e_evict = (h < 0) && m_tag[s][v][TW-1];
                m_tag[s][v]  = t;
                m_data[s][v] = d;
            end
            m_ts[s][v] = ++now;
        end
        @(posedge clk_i);
        #1;
        chk_outs(nm);
    endtask

    initial begin
        logic [LINE_W-1:0] new_c;
        rst_i = 1'b1;
        enable_i = 1'b0;
        write_i = 1'b0;
        addr_i = '0;
        tag_i = '0;
        data_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk_outs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        acc("rd_empty", 1, 0, 3, mk(1, 0, 1), '0);

        for (int i = 0; i < 4; i++) begin
            acc("fill", 1, 1, 5, mk(1, 0, 'hA + i), rnd_line());
            chk("fill_way", LINE_W'(way_o), LINE_W'(i));
        end
        for (int i = 0; i < 4; i++)
            acc("rd_fill", 1, 0, 5, mk(1, 0, 'hA + i), '0);

        acc("rd_a", 1, 0, 5, mk(1, 0, 'hA), '0);
        acc("wr_e", 1, 1, 5, mk(1, 0, 'hE), rnd_line());
        chk("evict_b_way", LINE_W'(way_o), LINE_W'(1));
        chk("evict_b_flag", LINE_W'(evict_o), LINE_W'(1));
        chk("evict_b_tag", LINE_W'(tag_o), LINE_W'(mk(1, 0, 'hB)));
        acc("rd_b_gone", 1, 0, 5, mk(1, 0, 'hB), '0);

        new_c = rnd_line();
        acc("wr_c_dirty", 1, 1, 5, mk(1, 1, 'hC), new_c);
        chk("wr_c_way", LINE_W'(way_o), LINE_W'(2));
        acc("rd_c", 1, 0, 5, mk(0, 0, 'hC), '0);
        chk("rd_c_data", data_o, new_c);
        chk("rd_c_tag", LINE_W'(tag_o), LINE_W'(mk(1, 1, 'hC)));

        for (int i = 0; i < 6; i++) begin
            acc("set0", 1, 1, 0, mk(1, 0, 'h100 + i), rnd_line());
            acc("set15", 1, 1, 15, mk(1, 0, 'h200 + i), rnd_line());
        end
        acc("idle", 0, 1, 15, mk(1, 0, 'h300), rnd_line());
        acc("set7", 1, 1, 7, mk(1, 0, 'h55), rnd_line());
        chk("set7_way", LINE_W'(way_o), LINE_W'(0));

        for (int i = 0; i < 400; i++) begin
            int sets_pool[4] = '{0, 1, 2, 7};
            acc("rand", $urandom_range(9) != 0, $urandom_range(1), sets_pool[$urandom_range(3)],
                mk($urandom_range(9) != 0, $urandom_range(1), $urandom_range(5)), rnd_line());
        end

        for (int i = 0; i < 6; i++)
            acc("stream", 1, 1, 9, mk(1, 0, 'h400 + i), rnd_line());
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 4'd9;
        tag_i    = mk(1, 0, 'h500);
        data_i   = rnd_line();
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        chk_outs("async_rst");
        chk("async_rst_hit", LINE_W'(hit_o), '0);
        @(posedge clk_i);
        #1;
        chk_outs("rst_hold");
        @(negedge clk_i);
        rst_i = 1'b0;
        enable_i = 1'b0;
        acc("post_rst", 1, 1, 9, mk(1, 0, 'h600), rnd_line());
        chk("post_rst_way", LINE_W'(way_o), '0);
        chk("post_rst_evict", LINE_W'(evict_o), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
